// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter.
//   state_e       : transmitter FSM states (IDLE = shifter empty, SHIFT = shifter loaded)
//   DEFAULT_WIDTH : default parallel word width
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register.
//   Clock      : rising-edge clock
//   reset      : synchronous active-low reset, clears the register
//   load_i     : load din_i into the register (wins over shift_en_i)
//   shift_en_i : advance the register by one bit
//   din_i      : parallel word
//   sout_o     : current serial bit (MSB or LSB end, chosen by MSB_FIRST)
module piso_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] sh_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= din_i;
    end else if (shift_en_i) begin
      // The bit just presented falls off the output end; zeros fill in.
      if (MSB_FIRST) sh_q <= {sh_q[WIDTH-2:0], 1'b0};
      else           sh_q <= {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  assign sout_o = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

endmodule

// File: rtl/serial_word_tx.sv
// Serialises parallel words onto a single data line with a one-word holding
// register so the next word can be queued while the current one shifts out.
//   Clock       : rising-edge clock
//   reset       : synchronous active-low reset
//   din         : parallel word to serialise
//   din_valid   : din holds a word
//   din_ready   : a word can be accepted this cycle (holding register empty)
//   x           : serial data bit (0 when x_valid is 0)
//   x_valid     : x carries a data bit
//   frame_start : pulse with bit 0 of every word
//   busy        : shifter or holding register occupied
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             last_bit;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] load_word;
  logic             sout;

  assign accept   = din_valid && din_ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    shift_en    = 1'b0;
    load_word   = din;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Reload on the last bit so the next word follows with no bubble.
          // A full hold keeps din_ready low, so hold and din never compete.
          cnt_d = '0;
          if (hold_full_q) begin
            load        = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  // NOTE: the held payload is not reset; hold_full_q alone says whether it is
  // meaningful, so clearing the data bits would add reset fan-out for nothing.
  always_ff @(posedge Clock) begin
    hold_q <= hold_d;
  end

  piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .Clock      (Clock),
    .reset      (reset),
    .load_i     (load),
    .shift_en_i (shift_en),
    .din_i      (load_word),
    .sout_o     (sout)
  );

  // Outputs come from registered state, forced quiet while reset is held.
  assign din_ready   = reset && !hold_full_q;
  assign x_valid     = reset && (state_q == SHIFT);
  assign frame_start = x_valid && (cnt_q == '0);
  assign x           = x_valid && sout;
  assign busy        = reset && ((state_q == SHIFT) || hold_full_q);

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx. Three instances run side by side:
//   dut 0: WIDTH=4, MSB first   dut 1: WIDTH=4, LSB first   dut 2: WIDTH=8, MSB first
// A queue-style reference model (words waiting + bits left in the current
// word) predicts every output on every cycle; literal bit streams pin it.
module tb_serial_word_tx;

  logic        Clock = 1'b0;
  logic        rst;
  logic [15:0] din_s [3];
  logic        vld_s [3];
  logic        rdy_w [3];
  logic        x_w   [3];
  logic        xv_w  [3];
  logic        fs_w  [3];
  logic        busy_w[3];

  always #10 Clock = ~Clock;

  serial_word_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
    .Clock(Clock), .reset(rst), .din(din_s[0][3:0]), .din_valid(vld_s[0]),
    .din_ready(rdy_w[0]), .x(x_w[0]), .x_valid(xv_w[0]),
    .frame_start(fs_w[0]), .busy(busy_w[0]));

  serial_word_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
    .Clock(Clock), .reset(rst), .din(din_s[1][3:0]), .din_valid(vld_s[1]),
    .din_ready(rdy_w[1]), .x(x_w[1]), .x_valid(xv_w[1]),
    .frame_start(fs_w[1]), .busy(busy_w[1]));

  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut2 (
    .Clock(Clock), .reset(rst), .din(din_s[2][7:0]), .din_valid(vld_s[2]),
    .din_ready(rdy_w[2]), .x(x_w[2]), .x_valid(xv_w[2]),
    .frame_start(fs_w[2]), .busy(busy_w[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state per instance.
  int          mw  [3] = '{4, 4, 8};
  bit          mmsb[3] = '{1'b1, 1'b0, 1'b1};
  int          bl  [3];            // bits of the current word still to present
  logic [15:0] cur [3];            // word being presented
  bit          pv  [3];            // a word is waiting behind the current one
  logic [15:0] pw  [3];            // the waiting word
  bit          acc_q[3];           // model accepted a word at the last edge

  // Observed serial stream per instance, newest bit in bit 0.
  logic [63:0] stream  [3];
  int          stream_n[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      bl[i] = 0; pv[i] = 0; cur[i] = '0; pw[i] = '0; acc_q[i] = 0;
      stream[i] = '0; stream_n[i] = 0;
    end
  end

  // Model update on each edge, then one comparison of all outputs per instance.
  always @(posedge Clock) begin
    for (int i = 0; i < 3; i++) begin
      acc_q[i] = 1'b0;
      if (!rst) begin
        bl[i] = 0;
        pv[i] = 1'b0;
      end else begin
        if (vld_s[i] && !pv[i]) begin
          pv[i] = 1'b1; pw[i] = din_s[i]; acc_q[i] = 1'b1;
        end
        if (bl[i] > 1) bl[i]--;
        else if (pv[i]) begin cur[i] = pw[i]; pv[i] = 1'b0; bl[i] = mw[i]; end
        else bl[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [4:0] exp_v, got_v;
      logic       ebit;
      int         p;
      exp_v = '0;
      if (rst) begin
        p    = mw[i] - bl[i];
        ebit = mmsb[i] ? cur[i][mw[i]-1-p] : cur[i][p];
        exp_v[4] = (bl[i] > 0) && ebit;        // x
        exp_v[3] = (bl[i] > 0);                // x_valid
        exp_v[2] = (bl[i] == mw[i]);           // frame_start
        exp_v[1] = (bl[i] > 0) || pv[i];       // busy
        exp_v[0] = !pv[i];                     // din_ready
      end
      got_v = {x_w[i], xv_w[i], fs_w[i], busy_w[i], rdy_w[i]};
      check($sformatf("cycle dut%0d {x,x_valid,frame_start,busy,din_ready}", i), 64'(got_v), 64'(exp_v));
      if (xv_w[i]) begin
        stream[i] = {stream[i][62:0], x_w[i]};
        stream_n[i]++;
      end
    end
  end

  task automatic clr(input int i);
    stream[i]   = '0;
    stream_n[i] = 0;
  endtask

  // Present a word and keep din_valid high until the model reports acceptance.
  task automatic send(input int i, input logic [15:0] w);
    bit got;
    got = 1'b0;
    @(negedge Clock);
    din_s[i] = w;
    vld_s[i] = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(posedge Clock);
      #2;
      got = acc_q[i];
    end
    if (!got) check($sformatf("accept timeout dut%0d", i), 64'(got), 64'd1);
  endtask

  task automatic idle(input int i, input int n);
    @(negedge Clock);
    vld_s[i] = 1'b0;
    repeat (n) @(posedge Clock);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin din_s[i] = '0; vld_s[i] = 1'b0; end
    repeat (3) @(posedge Clock);
    #2;
    check("reset din_ready dut0", 64'(rdy_w[0]), 64'd0);
    check("reset busy dut0", 64'(busy_w[0]), 64'd0);
    @(negedge Clock);
    rst = 1'b1;

    // Single word, MSB first: 1011 -> 1,0,1,1
    clr(0);
    send(0, 16'h000B);
    idle(0, 7);
    check("single word bits", stream[0][15:0], 64'h000B);
    check("single word count", 64'(stream_n[0]), 64'd4);
    check("single word busy after", 64'(busy_w[0]), 64'd0);

    // Back-to-back: 1110 then 0001 -> 11100001 with no gap
    clr(0);
    send(0, 16'h000E);
    send(0, 16'h0001);
    idle(0, 10);
    check("back-to-back bits", stream[0][15:0], 64'h00E1);
    check("back-to-back count", 64'(stream_n[0]), 64'd8);

    // Backpressure: three words in a row, third waits for the hold to drain
    clr(0);
    send(0, 16'h000A);
    send(0, 16'h0006);
    check("hold full din_ready", 64'(rdy_w[0]), 64'd0);
    send(0, 16'h000D);
    idle(0, 14);
    check("backpressure bits", stream[0][15:0], 64'h0A6D);
    check("backpressure count", 64'(stream_n[0]), 64'd12);

    // Reset after the 2nd bit of 1001 with 1111 held: both words discarded
    clr(0);
    send(0, 16'h0009);
    send(0, 16'h000F);
    @(negedge Clock);
    rst = 1'b0;
    vld_s[0] = 1'b0;
    @(posedge Clock);
    #2;
    check("mid-word reset outputs", 64'({x_w[0], xv_w[0], busy_w[0], rdy_w[0]}), 64'd0);
    @(posedge Clock);
    check("mid-word reset bits", stream[0][15:0], 64'h0002);
    check("mid-word reset count", 64'(stream_n[0]), 64'd2);
    clr(0);
    @(negedge Clock);
    rst = 1'b1;
    din_s[0] = 16'h0006;
    vld_s[0] = 1'b1;
    @(posedge Clock);
    #2;
    check("first edge after reset accepts", 64'(acc_q[0]), 64'd1);
    idle(0, 7);
    check("after reset bits", stream[0][15:0], 64'h0006);
    check("after reset count", 64'(stream_n[0]), 64'd4);

    // LSB first: 1011 -> 1,1,0,1
    clr(1);
    send(1, 16'h000B);
    idle(1, 7);
    check("lsb first bits", stream[1][15:0], 64'h000D);
    check("lsb first count", 64'(stream_n[1]), 64'd4);

    // WIDTH=8: A5 then 3C back-to-back, counter wraps on reload
    clr(2);
    send(2, 16'h00A5);
    send(2, 16'h003C);
    idle(2, 20);
    check("width8 bits", stream[2][15:0], 64'hA53C);
    check("width8 count", 64'(stream_n[2]), 64'd16);

    repeat (3) @(posedge Clock);
    #5;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits, legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB first.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 din  input  WIDTH  parallel word to serialise.
REQ-006 din_valid  input  1  din holds a word to transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  serial data bit; feeds the downstream serial detector/shifter.
REQ-009 x_valid  output  1  x carries a data bit this cycle.
REQ-010 frame_start  output  1  one-cycle pulse coincident with bit 0 of each word.
REQ-011 busy  output  1  shifter or holding register occupied.

Function
REQ-012 The block SHALL accept a word on any rising edge where din_valid=1 and din_ready=1; no other condition transfers a word.
REQ-013 din_ready SHALL equal (holding register empty) AND reset=1. It is driven from registered state only.
REQ-014 The block SHALL use two storage stages: a shifter (SHIFT state) and a one-word holding register.
REQ-015 The FSM SHALL have the states IDLE (shifter empty) and SHIFT (shifter loaded, bit counter 0..WIDTH-1).
REQ-016 An accepted word SHALL load directly into the shifter in either of these cases: the FSM is IDLE, or the FSM is in SHIFT with bit counter = WIDTH-1. Otherwise the word SHALL go to the holding register.
REQ-017 Latency: a word accepted at edge k into the shifter SHALL present its first bit on x, with x_valid=1 and frame_start=1, in the cycle after edge k. The remaining bits follow on consecutive cycles, WIDTH cycles total.
REQ-018 At the last bit (counter = WIDTH-1), a full holding register SHALL move to the shifter on the same edge. The next word's bit 0 follows with no bubble, and the holding register empties.
REQ-019 At the last bit with the holding register empty and no accepted word, the FSM SHALL return to IDLE.
REQ-020 The bit counter SHALL wrap from WIDTH-1 to 0 on each reload. It SHALL never exceed WIDTH-1.
REQ-021 When x_valid=0, x SHALL be 0 and frame_start SHALL be 0.
REQ-022 busy SHALL be 1 whenever the FSM is in SHIFT or the holding register is full.
REQ-023 When the holding register is full, din_ready=0. A presented word SHALL be held off with no loss and no duplication, even on a cycle where the hold drains.
REQ-024 The bit order SHALL follow MSB_FIRST. With MSB_FIRST=1, din=4'b1011 yields x sequence 1,0,1,1.

Reset
REQ-025 On an edge with reset=0, the block SHALL clear the following: FSM to IDLE, bit counter to 0, shifter to 0, holding register empty.
REQ-026 While reset=0, the outputs SHALL be: x=0, x_valid=0, frame_start=0, busy=0, din_ready=0.
REQ-027 A reset asserted mid-word SHALL discard both the in-flight word and the held word. No partial bits appear after reset releases.
REQ-028 The first edge with reset=1 and din_valid=1 SHALL accept a word per REQ-012.

Structure
REQ-029 A shared package serial_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-030 A sub-module piso_shift SHALL implement the parallel-load shift register. Its interface is load, shift enable, MSB_FIRST and serial out. The FSM, counter and holding register live in serial_word_tx.

Verification (WIDTH=4 unless noted; Clock period 20 ns)
REQ-031 Single word, MSB_FIRST=1: din=4'b1011 accepted at edge k → cycles k+1..k+4 carry x=1,0,1,1 with x_valid=1 and frame_start=1 only at k+1. At k+5: x_valid=0, busy=0.
REQ-032 Back-to-back: 4'b1110 then 4'b0001 with din_valid held → 8 contiguous valid bits 1,1,1,0,0,0,0,1, with frame_start at bit 0 and bit 4.
REQ-033 Backpressure: three words presented continuously → din_ready=0 while the hold is full. The third word is accepted only after the hold drains, and all 12 bits arrive in order with none lost or duplicated.
REQ-034 Reset mid-word: reset=0 after the 2nd bit of 4'b1001 → the next cycle shows x=0, x_valid=0, busy=0, din_ready=0. After release, din=4'b0110 serialises cleanly as 0,1,1,0.
REQ-035 LSB first: MSB_FIRST=0, din=4'b1011 → x sequence 1,1,0,1.
REQ-036 Parameter check: WIDTH=8, din=8'hA5 → x = 1,0,1,0,0,1,0,1 over 8 cycles, with the counter wrapping to 0 on reload.
